// File: rtl/mslope_pkg.sv
// mslope_pkg: shared types, codes and saturation helper for the multi-slope sequencer
package mslope_pkg;
    typedef enum logic [2:0] {S_IDLE, S_SETTLE, S_START, S_WAIT, S_CALC, S_OUT} state_t;
    localparam logic [1:0] MUX_INPUT = 2'b00;
    localparam logic [1:0] MUX_ZERO = 2'b01;
    localparam int N64_SHIFT = 6;
    localparam int P8_SHIFT = 3;
    localparam int N1_SHIFT = 0;
    localparam int RES_W = 32;
    localparam int ACC_W = 40;
    localparam logic signed [ACC_W-1:0] ACC_MAX = 40'sh00_7FFF_FFFF;
    localparam logic signed [ACC_W-1:0] ACC_MIN = 40'shFF_8000_0000;

    function automatic logic signed [RES_W-1:0] sat_res(input logic signed [ACC_W-1:0] v);
        return (v > ACC_MAX) ? 32'sh7FFF_FFFF : (v < ACC_MIN) ? 32'sh8000_0000 : $signed(v[RES_W-1:0]);
    endfunction
endpackage

// File: rtl/mslope_conv_sequencer_if.sv
// mslope_conv_sequencer_if: front-end control/count bus and result valid/ready bus
interface mslope_conv_sequencer_if;
    logic [1:0]  mux_sel;
    logic        fe_start;
    logic        fe_done;
    logic [31:0] fe_ru_p;
    logic [31:0] fe_ru_n;
    logic [11:0] fe_rd;
    logic [7:0]  fe_n64;
    logic [7:0]  fe_p8;
    logic [7:0]  fe_n1;
    logic [31:0] res_data;
    logic        res_valid;
    logic        res_ready;

    modport master(
        output mux_sel, fe_start, res_data, res_valid,
        input  fe_done, fe_ru_p, fe_ru_n, fe_rd, fe_n64, fe_p8, fe_n1, res_ready
    );
    modport slave(
        input  mux_sel, fe_start, res_data, res_valid,
        output fe_done, fe_ru_p, fe_ru_n, fe_rd, fe_n64, fe_p8, fe_n1, res_ready
    );
endinterface

// File: rtl/mslope_result_calc.sv
// mslope_result_calc: 3-cycle weighted sum of captured counts, offset subtract and saturation
module mslope_result_calc
    import mslope_pkg::*;
#(
    parameter int RU_SHIFT = 9,
    parameter int RD_SHIFT = 9
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [31:0]             ru_p,
    input  logic [31:0]             ru_n,
    input  logic [11:0]             rd,
    input  logic [7:0]              n64,
    input  logic [7:0]              p8,
    input  logic [7:0]              n1,
    input  logic signed [RES_W-1:0] offset,
    output logic                    done,
    output logic signed [RES_W-1:0] result
);
    logic [1:0] v;
    logic signed [ACC_W-1:0] s1, s2, ru_term, rd_term, res_term, off_ext;

    always_comb begin
        ru_term = ($signed({{(ACC_W-32){1'b0}}, ru_p}) - $signed({{(ACC_W-32){1'b0}}, ru_n})) <<< RU_SHIFT;
        rd_term = $signed({{(ACC_W-12){1'b0}}, rd}) <<< RD_SHIFT;
        res_term = ($signed({{(ACC_W-8){1'b0}}, n64}) <<< N64_SHIFT)
                 - ($signed({{(ACC_W-8){1'b0}}, p8}) <<< P8_SHIFT)
                 + ($signed({{(ACC_W-8){1'b0}}, n1}) <<< N1_SHIFT);
        off_ext = $signed({{(ACC_W-RES_W){offset[RES_W-1]}}, offset});
        done = v[1];
        result = sat_res(s2 - off_ext);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v <= '0;
            s1 <= '0;
            s2 <= '0;
        end else begin
            v <= {v[0], start};
            if (start) s1 <= ru_term;
            if (v[0]) s2 <= s1 - rd_term + res_term;
        end
    end
endmodule

// File: rtl/mslope_conv_sequencer.sv
// mslope_conv_sequencer: sequences mux/settle/start/capture of the multi-slope front end,
// interleaves auto-zero measurements and hands offset-corrected results out over valid/ready
module mslope_conv_sequencer
    import mslope_pkg::*;
#(
    parameter int AZ_EVERY    = 16,
    parameter int SETTLE_CYC  = 250,
    parameter int TIMEOUT_CYC = 2000000,
    parameter int RU_SHIFT    = 9,
    parameter int RD_SHIFT    = 9
) (
    input  logic clk,
    input  logic rst,
    input  logic conv_req,
    input  logic cont_en,
    output logic busy,
    output logic timeout_err,
    output logic overrun,
    mslope_conv_sequencer_if.master bus
);
    localparam int MAXC = (TIMEOUT_CYC > SETTLE_CYC) ? TIMEOUT_CYC : SETTLE_CYC;
    localparam int CW = $clog2(MAXC + 1);
    localparam int AW = $clog2(AZ_EVERY + 1);

    state_t state, nxt;
    logic [CW-1:0] cnt;
    logic [AW-1:0] az_cnt;
    logic [1:0] mux_sel;
    logic pending, trigger, timed_out, is_zero, calc_start, calc_done;
    logic [31:0] ru_p, ru_n;
    logic [11:0] rd;
    logic [7:0] n64, p8, n1;
    logic signed [RES_W-1:0] zero_off, res_q, calc_res;

    assign trigger = cont_en | conv_req | pending;
    assign is_zero = mux_sel == MUX_ZERO;
    // a done arriving on the last allowed cycle beats the timeout
    assign timed_out = state == S_WAIT && !bus.fe_done && cnt == CW'(TIMEOUT_CYC - 1);
    assign calc_start = state == S_CALC && cnt == '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else state <= nxt;
    end

    always_comb begin
        nxt = state;
        case (state)
            S_IDLE:   nxt = trigger ? S_SETTLE : S_IDLE;
            S_SETTLE: nxt = (cnt == CW'(SETTLE_CYC - 1)) ? S_START : S_SETTLE;
            S_START:  nxt = S_WAIT;
            S_WAIT:   nxt = bus.fe_done ? S_CALC : timed_out ? S_IDLE : S_WAIT;
            S_CALC:   nxt = !calc_done ? S_CALC : is_zero ? S_SETTLE : S_OUT;
            S_OUT:    nxt = bus.res_ready ? S_IDLE : S_OUT;
            default:  nxt = S_IDLE;
        endcase
    end

    always_comb begin
        bus.fe_start = state == S_START;
        bus.res_valid = state == S_OUT;
        bus.mux_sel = mux_sel;
        bus.res_data = res_q;
        busy = state != S_IDLE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
            az_cnt <= '0;
            mux_sel <= MUX_ZERO;
            pending <= 1'b0;
            timeout_err <= 1'b0;
            overrun <= 1'b0;
            zero_off <= '0;
            res_q <= '0;
            {ru_p, ru_n, rd, n64, p8, n1} <= '0;
        end else begin
            cnt <= (state != nxt || state == S_IDLE) ? '0 : cnt + 1'b1;
            if (state == S_IDLE && trigger) mux_sel <= (az_cnt == '0) ? MUX_ZERO : MUX_INPUT;
            if (state == S_IDLE) pending <= 1'b0;
            else if (conv_req && !cont_en) pending <= 1'b1;
            if (state != S_IDLE && conv_req && !cont_en && pending) overrun <= 1'b1;
            if (state == S_WAIT && bus.fe_done)
                {ru_p, ru_n, rd, n64, p8, n1} <= {bus.fe_ru_p, bus.fe_ru_n, bus.fe_rd, bus.fe_n64, bus.fe_p8, bus.fe_n1};
            if (timed_out) begin
                timeout_err <= 1'b1;
                az_cnt <= '0;
            end
            if (state == S_CALC && calc_done) begin
                if (is_zero) begin
                    zero_off <= calc_res;
                    az_cnt <= AW'(AZ_EVERY);
                    mux_sel <= MUX_INPUT;
                end else begin
                    res_q <= calc_res;
                    az_cnt <= (az_cnt == '0) ? '0 : az_cnt - 1'b1;
                end
            end
        end
    end

    mslope_result_calc #(.RU_SHIFT(RU_SHIFT), .RD_SHIFT(RD_SHIFT)) u_calc (
        .clk(clk),
        .rst(rst),
        .start(calc_start),
        .ru_p(ru_p),
        .ru_n(ru_n),
        .rd(rd),
        .n64(n64),
        .p8(p8),
        .n1(n1),
        .offset(is_zero ? '0 : zero_off),
        .done(calc_done),
        .result(calc_res)
    );
endmodule

// File: tb/tb_mslope_conv_sequencer.sv
// tb_mslope_conv_sequencer: vector table plus multi-cycle corner sequences, queue-based scoreboard
module tb_mslope_conv_sequencer;
    import mslope_pkg::*;
    localparam int AZ = 16, ST = 8, TO = 300;

    logic clk = 0, rst = 0, conv_req = 0, cont_en = 0;
    logic busy, timeout_err, overrun;
    mslope_conv_sequencer_if bus();

    mslope_conv_sequencer #(.AZ_EVERY(AZ), .SETTLE_CYC(ST), .TIMEOUT_CYC(TO), .RU_SHIFT(9), .RD_SHIFT(9)) dut (
        .clk(clk), .rst(rst), .conv_req(conv_req), .cont_en(cont_en),
        .busy(busy), .timeout_err(timeout_err), .overrun(overrun), .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] ru_p, ru_n;
        logic [11:0] rd;
        logic [7:0] n64, p8, n1;
        int dly;
    } rsp_t;
    typedef struct {rsp_t z; rsp_t i; longint exp;} vec_t;

    rsp_t rsp_q[$];
    logic [1:0] exp_mux_q[$];
    longint exp_res_q[$];
    int total = 0, bad = 0, served = 0;

    function automatic rsp_t mk(logic [31:0] ru_p, logic [31:0] ru_n, logic [11:0] rd,
                                logic [7:0] n64, logic [7:0] p8, logic [7:0] n1, int dly);
        return '{ru_p, ru_n, rd, n64, p8, n1, dly};
    endfunction

    task automatic chk(string n, longint act, longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", n, act, exp);
        end
    endtask

    task automatic unexpected(string n);
        total++;
        bad++;
        $display("FAIL %s got=event want=none", n);
    endtask

    // front-end model: answers each fe_start with the next queued response after dly cycles
    initial begin
        rsp_t r;
        bus.fe_done = 0;
        {bus.fe_ru_p, bus.fe_ru_n, bus.fe_rd, bus.fe_n64, bus.fe_p8, bus.fe_n1} = '0;
        forever begin
            @(posedge clk);
            #1;
            if (bus.fe_start) begin
                served++;
                if (exp_mux_q.size() == 0) unexpected("fe_start");
                else chk("mux_sel", bus.mux_sel, exp_mux_q.pop_front());
                if (rsp_q.size() != 0) begin
                    r = rsp_q.pop_front();
                    if (r.dly > 0) begin
                        repeat (r.dly) @(posedge clk);
                        #1;
                        {bus.fe_ru_p, bus.fe_ru_n, bus.fe_rd} = {r.ru_p, r.ru_n, r.rd};
                        {bus.fe_n64, bus.fe_p8, bus.fe_n1} = {r.n64, r.p8, r.n1};
                        bus.fe_done = 1;
                        @(posedge clk);
                        #1;
                        bus.fe_done = 0;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (bus.res_valid && bus.res_ready) begin
            if (exp_res_q.size() == 0) unexpected("res_handshake");
            else chk("res_data", $signed(bus.res_data), exp_res_q.pop_front());
        end
    end

    task automatic pulse_req();
        @(posedge clk);
        #1 conv_req = 1;
        @(posedge clk);
        #1 conv_req = 0;
    endtask

    task automatic do_reset();
        #1 rst = 0;
        conv_req = 0;
        cont_en = 0;
        bus.res_ready = 1;
        rsp_q.delete();
        exp_mux_q.delete();
        exp_res_q.delete();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_mux", bus.mux_sel, 1);
        chk("rst_start", bus.fe_start, 0);
        chk("rst_valid", bus.res_valid, 0);
        chk("rst_data", bus.res_data, 0);
        chk("rst_tmo", timeout_err, 0);
        chk("rst_ovr", overrun, 0);
        rst = 1;
        served = 0;
    endtask

    task automatic drain(int lim);
        int n = 0;
        while ((exp_res_q.size() != 0 || exp_mux_q.size() != 0) && n < lim) begin
            @(posedge clk);
            n++;
        end
        chk("drain_left", exp_res_q.size() + exp_mux_q.size(), 0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    vec_t vecs[9];

    initial begin
        vecs[0] = '{mk(100, 90, 20, 3, 2, 5, 2), mk(100, 90, 20, 3, 2, 5, 3), 0};
        vecs[1] = '{mk(0, 0, 0, 0, 0, 0, 1), mk(10, 0, 1, 1, 1, 1, 4), 4665};
        vecs[2] = '{mk(0, 0, 0, 0, 0, 7, 5), mk(0, 0, 0, 0, 0, 0, 1), -7};
        vecs[3] = '{mk(0, 0, 0, 0, 0, 0, 2), mk(32'h0040_0000, 0, 0, 0, 0, 0, 2), 2147483647};
        vecs[4] = '{mk(0, 0, 0, 0, 0, 0, 2), mk(0, 32'h0040_0000, 0, 0, 0, 0, 2), -64'sd2147483648};
        vecs[5] = '{mk(0, 0, 0, 0, 0, 0, 2), mk(0, 32'h0040_0001, 0, 0, 0, 0, 2), -64'sd2147483648};
        vecs[6] = '{mk(0, 32'h0080_0000, 0, 0, 0, 0, 3), mk(32'h003F_FFFF, 0, 0, 0, 0, 0, TO), 2147483647};
        vecs[7] = '{mk(5, 7, 300, 255, 255, 255, 6), mk(1000, 20, 4095, 0, 255, 0, 9), -1456831};
        vecs[8] = '{mk(0, 1, 0, 0, 0, 0, 1), mk(0, 0, 0, 0, 0, 0, 1), 512};

        for (int v = 0; v < 9; v++) begin
            do_reset();
            exp_mux_q.push_back(MUX_ZERO);
            exp_mux_q.push_back(MUX_INPUT);
            rsp_q.push_back(vecs[v].z);
            rsp_q.push_back(vecs[v].i);
            exp_res_q.push_back(vecs[v].exp);
            pulse_req();
            drain(2 * (ST + TO + 20) + 50);
            chk("vec_busy", busy, 0);
            chk("vec_tmo", timeout_err, 0);
        end

        // 17 free-running conversions: auto-zero only before the 1st and 17th input
        do_reset();
        for (int k = 0; k < 17; k++) begin
            if (k == 0 || k == 16) begin
                exp_mux_q.push_back(MUX_ZERO);
                rsp_q.push_back(mk(0, 0, 0, 0, 0, 3, 2));
            end
            exp_mux_q.push_back(MUX_INPUT);
            rsp_q.push_back(mk(k + 1, 0, 0, 0, 0, 0, 1 + k % 4));
            exp_res_q.push_back((k + 1) * 512 - 3);
        end
        @(posedge clk);
        #1 cont_en = 1;
        for (int n = 0; n < 2000 && served < 19; n++) @(posedge clk);
        #1 cont_en = 0;
        drain(200);
        chk("cont_busy", busy, 0);
        chk("cont_starts", served, 19);

        // timeout during the input measurement, then recovery with a fresh auto-zero
        do_reset();
        exp_mux_q.push_back(MUX_ZERO);
        exp_mux_q.push_back(MUX_INPUT);
        rsp_q.push_back(mk(0, 0, 0, 0, 0, 0, 2));
        rsp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0));
        pulse_req();
        for (int n = 0; n < 2 * (ST + TO) + 100 && !timeout_err; n++) @(negedge clk);
        @(negedge clk);
        chk("tmo_err", timeout_err, 1);
        chk("tmo_busy", busy, 0);
        chk("tmo_valid", bus.res_valid, 0);
        exp_mux_q.push_back(MUX_ZERO);
        exp_mux_q.push_back(MUX_INPUT);
        rsp_q.push_back(mk(0, 0, 0, 0, 0, 2, 3));
        rsp_q.push_back(mk(0, 0, 0, 0, 0, 9, 4));
        exp_res_q.push_back(7);
        pulse_req();
        drain(200);
        chk("tmo_sticky", timeout_err, 1);

        // consumer stall plus two requests while busy
        do_reset();
        bus.res_ready = 0;
        exp_mux_q.push_back(MUX_ZERO);
        exp_mux_q.push_back(MUX_INPUT);
        exp_mux_q.push_back(MUX_INPUT);
        rsp_q.push_back(mk(0, 0, 0, 0, 0, 1, 2));
        rsp_q.push_back(mk(0, 0, 0, 0, 0, 11, 3));
        rsp_q.push_back(mk(1, 0, 0, 0, 0, 0, 5));
        exp_res_q.push_back(10);
        exp_res_q.push_back(511);
        pulse_req();
        repeat (4) @(posedge clk);
        pulse_req();
        @(negedge clk);
        chk("ovr_one_req", overrun, 0);
        pulse_req();
        @(negedge clk);
        chk("ovr_set", overrun, 1);
        begin
            int n = 0, ch = 0;
            logic [31:0] d;
            while (!bus.res_valid && n < 200) begin
                @(negedge clk);
                n++;
            end
            chk("stall_valid", bus.res_valid, 1);
            d = bus.res_data;
            chk("stall_data", $signed(d), 10);
            for (int k = 0; k < 100; k++) begin
                @(negedge clk);
                if (!bus.res_valid || bus.res_data !== d) ch++;
            end
            chk("stall_hold", ch, 0);
        end
        @(posedge clk);
        #1 bus.res_ready = 1;
        drain(200);
        repeat (20) @(posedge clk);
        #1;
        chk("pend_busy", busy, 0);
        chk("pend_starts", served, 3);

        // asynchronous reset while waiting for fe_done
        do_reset();
        exp_mux_q.push_back(MUX_ZERO);
        rsp_q.push_back(mk(7, 0, 0, 0, 0, 0, 40));
        pulse_req();
        for (int n = 0; n < 100 && served < 1; n++) @(posedge clk);
        repeat (5) @(posedge clk);
        #2 rst = 0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_mux", bus.mux_sel, 1);
        chk("arst_start", bus.fe_start, 0);
        chk("arst_valid", bus.res_valid, 0);
        @(posedge clk);
        #1 rst = 1;
        repeat (60) @(posedge clk);
        #1;
        chk("arst_ignore_busy", busy, 0);
        chk("arst_ignore_valid", bus.res_valid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end
endmodule
